gpr_wb_arbiter: RTL and testbench
=================================

# gpr_wb_arbiter

Shares the single write port of the pipeline GPR file between two writeback sources. Source 0 is the in-order pipeline writeback; source 1 is the multi-cycle MDU (mul/div). Arbitration is round-robin, and the granted write goes through one output register. A 32-entry pending-write scoreboard tracks MDU destinations and produces the issue-stage stall for RAW and WAW hazards.

## Interface
Parameters:
- XLEN, 64: data width of GPR writes.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- wb0_valid  input  1  pipeline writeback request.
- wb0_ready  output  1  pipeline request accepted this cycle.
- wb0_rd  input  5  pipeline destination index.
- wb0_data  input  XLEN  pipeline write data.
- wb1_valid  input  1  MDU writeback request.
- wb1_ready  output  1  MDU request accepted this cycle.
- wb1_rd  input  5  MDU destination index.
- wb1_data  input  XLEN  MDU write data.
- sb_set  input  1  an MDU op with destination sb_rd is issued this cycle.
- sb_rd  input  5  destination of the issuing MDU op.
- chk_rs1, chk_rs2, chk_rd  input  5 each  operands of the instruction in issue.
- stall  output  1  issue must hold: a checked index is pending.
- gpr_wr_en  output  1  write enable to the GPR file.
- gpr_index_rd  output  5  write index to the GPR file.
- gpr_data_rd  output  XLEN  write data to the GPR file.
- fwd_rs1_hit, fwd_rs2_hit  output  1 each  bypass hit (only with GPR_WB_FWD_EN).
- fwd_data  output  XLEN  bypass data, equal to gpr_data_rd (only with GPR_WB_FWD_EN).

## Operation
**Arbitration**
- A request is accepted when valid and ready are both high at a rising edge.
- Only one valid: that source is granted.
- Both valid: the source not granted last is granted.
- The last_grant bit updates only on an actual grant; its reset value is 1, so source 0 wins the first tie.
- ready is combinational from valid and last_grant. No dependence on the output stage: the register drains every cycle.
- A source must hold valid, rd and data stable until accepted.

**Output stage**
- On acceptance: gpr_index_rd and gpr_data_rd load the request, and gpr_wr_en is set to (rd != 0).
- With no acceptance: gpr_wr_en = 0 and index/data hold their previous values.
- An accepted request with rd = 0 is consumed and never produces gpr_wr_en.

**Scoreboard**
- busy[31:0], with busy[0] hardwired to 0.
- sb_set with sb_rd != 0 sets busy[sb_rd].
- An accepted source-1 request with wb1_rd != 0 clears busy[wb1_rd] at the acceptance edge.
- Set and clear of the same index in one cycle: set wins (new op supersedes).
- stall = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd], combinational.
- Source-0 writes never touch busy.

## Timing
- Reset (async assert): gpr_wr_en = 0, gpr_index_rd = 0, gpr_data_rd = 0, busy = 0, last_grant = 1, stall = 0, fwd_* = 0.
- Deassertion is synchronised externally; the first grant happens on the first edge after release.
- Latency: accepted at edge N → gpr_wr_en high during cycle N..N+1 → GPR file written at edge N+1.
- A reset asserted mid-operation drops any in-flight output write and clears all busy bits. The MDU is reset in the same domain.
- Throughput: one write per cycle. Under continuous dual requests the grants alternate strictly.
- The stall from sb_set is visible the cycle after the set edge. A stall clears the cycle after the MDU acceptance edge.

## Configuration
- GPR_WB_FWD_EN defined: fwd_rsX_hit = gpr_wr_en & (gpr_index_rd == chk_rsX) & (chk_rsX != 0), and fwd_data = gpr_data_rd. This covers the cycle in which the GPR file still returns the old value.
- GPR_WB_FWD_EN undefined: fwd outputs are tied to 0. The pipeline then inserts its own one-cycle delay after any write to a read operand.

## Test plan
- Reset, then wb0 only (rd=5, data=0x11) → wb0_ready=1, gpr_wr_en=1 with index 5 and data 0x11 one cycle later, then gpr_wr_en=0.
- Both valid for 4 cycles right after reset → grant order 0,1,0,1; gpr_index_rd follows wb0_rd/wb1_rd alternately.
- sb_set rd=7; next cycle chk_rs2=7 → stall=1. wb1 accepted with rd=7 → stall=0 the next cycle; regfile reads the new value after edge N+1.
- Same cycle: sb_set rd=9 and wb1 accepted with rd=9 → busy[9] stays 1, stall remains for chk_rd=9.
- wb1 rd=0 with data 0xFF accepted → wb1_ready=1, gpr_wr_en stays 0, busy unchanged. sb_set rd=0 → no stall.
- Async rstn pulse mid-cycle while busy[3]=1 and gpr_wr_en=1 → outputs zero immediately, busy cleared. With GPR_WB_FWD_EN, verify fwd_rs1_hit=1 for chk_rs1 equal to gpr_index_rd and 0 when that index is x0.

Source files
------------

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: round-robin merge of the pipeline writeback (source 0) and the MDU writeback
// (source 1) onto the single GPR write port through one output register, plus a 32-entry
// pending-write scoreboard over MDU destinations that drives the issue-stage stall.
// Optional bypass outputs are enabled by defining GPR_WB_FWD_EN.
module gpr_wb_arbiter #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            wb0_valid,
    output logic            wb0_ready,
    input  logic [4:0]      wb0_rd,
    input  logic [XLEN-1:0] wb0_data,
    input  logic            wb1_valid,
    output logic            wb1_ready,
    input  logic [4:0]      wb1_rd,
    input  logic [XLEN-1:0] wb1_data,
    input  logic            sb_set,
    input  logic [4:0]      sb_rd,
    input  logic [4:0]      chk_rs1,
    input  logic [4:0]      chk_rs2,
    input  logic [4:0]      chk_rd,
    output logic            stall,
    output logic            gpr_wr_en,
    output logic [4:0]      gpr_index_rd,
    output logic [XLEN-1:0] gpr_data_rd,
    output logic            fwd_rs1_hit,
    output logic            fwd_rs2_hit,
    output logic [XLEN-1:0] fwd_data
);

    logic            grant0;
    logic            grant1;
    logic            last_grant_q;  // 1: source 1 was granted last
    logic            last_grant_d;
    logic            wr_en_q;
    logic            wr_en_d;
    logic [4:0]      index_q;
    logic [4:0]      index_d;
    logic [XLEN-1:0] data_q;
    logic [XLEN-1:0] data_d;
    logic [31:0]     busy_q;
    logic [31:0]     busy_d;

    // Round-robin grant; a tie goes to the source not granted last.
    always_comb begin
        grant0       = wb0_valid & (~wb1_valid | last_grant_q);
        grant1       = wb1_valid & (~wb0_valid | ~last_grant_q);
        last_grant_d = last_grant_q;
        if (grant0) begin
            last_grant_d = 1'b0;
        end else if (grant1) begin
            last_grant_d = 1'b1;
        end
    end

    assign wb0_ready = grant0;
    assign wb1_ready = grant1;

    // Output stage: load the granted request; rd = 0 is consumed without a write.
    always_comb begin
        wr_en_d = 1'b0;
        index_d = index_q;
        data_d  = data_q;
        if (grant0) begin
            wr_en_d = (wb0_rd != 5'd0);
            index_d = wb0_rd;
            data_d  = wb0_data;
        end else if (grant1) begin
            wr_en_d = (wb1_rd != 5'd0);
            index_d = wb1_rd;
            data_d  = wb1_data;
        end
    end

    // Scoreboard next state: MDU acceptance clears, a new issue sets and wins on collision.
    always_comb begin
        busy_d = busy_q;
        if (grant1 && (wb1_rd != 5'd0)) begin
            busy_d[wb1_rd] = 1'b0;
        end
        if (sb_set && (sb_rd != 5'd0)) begin
            busy_d[sb_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers; asynchronous reset drops any in-flight write and all pending bits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant_q <= 1'b1;
            wr_en_q      <= 1'b0;
            index_q      <= 5'd0;
            data_q       <= '0;
            busy_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            index_q      <= index_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
        end
    end

    assign gpr_wr_en    = wr_en_q;
    assign gpr_index_rd = index_q;
    assign gpr_data_rd  = data_q;

    // Issue stall whenever any checked operand has an outstanding MDU write.
    always_comb begin
        stall = busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[chk_rd];
    end

`ifdef GPR_WB_FWD_EN
    // Bypass covers the cycle in which the GPR file still returns the old value.
    always_comb begin
        fwd_rs1_hit = wr_en_q & (index_q == chk_rs1) & (chk_rs1 != 5'd0);
        fwd_rs2_hit = wr_en_q & (index_q == chk_rs2) & (chk_rs2 != 5'd0);
        fwd_data    = data_q;
    end
`else
    // No bypass: the pipeline inserts its own delay after a write to a read operand.
    always_comb begin
        fwd_rs1_hit = 1'b0;
        fwd_rs2_hit = 1'b0;
        fwd_data    = '0;
    end
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: arbitration, output stage, scoreboard, async reset.
module tb_gpr_wb_arbiter;
    localparam int unsigned XLEN = 64;

    logic            clk;
    logic            rstn;
    logic            wb0_valid;
    logic            wb0_ready;
    logic [4:0]      wb0_rd;
    logic [XLEN-1:0] wb0_data;
    logic            wb1_valid;
    logic            wb1_ready;
    logic [4:0]      wb1_rd;
    logic [XLEN-1:0] wb1_data;
    logic            sb_set;
    logic [4:0]      sb_rd;
    logic [4:0]      chk_rs1;
    logic [4:0]      chk_rs2;
    logic [4:0]      chk_rd;
    logic            stall;
    logic            gpr_wr_en;
    logic [4:0]      gpr_index_rd;
    logic [XLEN-1:0] gpr_data_rd;
    logic            fwd_rs1_hit;
    logic            fwd_rs2_hit;
    logic [XLEN-1:0] fwd_data;

    int checks;
    int failures;

    gpr_wb_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .rstn(rstn),
        .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
        .sb_set(sb_set), .sb_rd(sb_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .stall(stall),
        .gpr_wr_en(gpr_wr_en), .gpr_index_rd(gpr_index_rd), .gpr_data_rd(gpr_data_rd),
        .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit), .fwd_data(fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        wb0_valid = 1'b0; wb0_rd = 5'd0; wb0_data = '0;
        wb1_valid = 1'b0; wb1_rd = 5'd0; wb1_data = '0;
        sb_set = 1'b0; sb_rd = 5'd0;
        chk_rs1 = 5'd0; chk_rs2 = 5'd0; chk_rd = 5'd0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        idle_inputs();
        rstn = 1'b0;
        #2 rstn = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        #3;
        checks++; if (gpr_wr_en !== 1'b0) begin failures++;
            $display("FAIL rst_wr_en got=%0b exp=0", gpr_wr_en); end
        checks++; if (gpr_index_rd !== 5'd0) begin failures++;
            $display("FAIL rst_index got=%0d exp=0", gpr_index_rd); end
        checks++; if (gpr_data_rd !== 64'd0) begin failures++;
            $display("FAIL rst_data got=%0h exp=0", gpr_data_rd); end
        checks++; if (stall !== 1'b0) begin failures++;
            $display("FAIL rst_stall got=%0b exp=0", stall); end
        checks++; if ({fwd_rs1_hit, fwd_rs2_hit, fwd_data} !== '0) begin failures++;
            $display("FAIL rst_fwd got=%0b%0b/%0h exp=0", fwd_rs1_hit, fwd_rs2_hit, fwd_data); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_wb0_only();
        @(negedge clk);
        wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 64'h11;
        #1;
        checks++; if ({wb0_ready, wb1_ready} !== 2'b10) begin failures++;
            $display("FAIL wb0_ready got=%b exp=10", {wb0_ready, wb1_ready}); end
        @(posedge clk); #1;
        checks++; if ({gpr_wr_en, gpr_index_rd, gpr_data_rd} !== {1'b1, 5'd5, 64'h11}) begin
            failures++;
            $display("FAIL wb0_write got=%0b/%0d/%0h exp=1/5/11",
                     gpr_wr_en, gpr_index_rd, gpr_data_rd); end
        @(negedge clk);
        wb0_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if ({gpr_wr_en, gpr_index_rd, gpr_data_rd} !== {1'b0, 5'd5, 64'h11}) begin
            failures++;
            $display("FAIL wb0_idle_hold got=%0b/%0d/%0h exp=0/5/11",
                     gpr_wr_en, gpr_index_rd, gpr_data_rd); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_ready;
        logic [4:0] exp_idx;
        pulse_reset();
        @(negedge clk);
        wb0_valid = 1'b1; wb0_rd = 5'd10; wb0_data = 64'hA0;
        wb1_valid = 1'b1; wb1_rd = 5'd20; wb1_data = 64'hB1;
        for (int i = 0; i < 4; i++) begin
            exp_ready = (i % 2 == 0) ? 2'b10 : 2'b01;
            exp_idx   = (i % 2 == 0) ? 5'd10 : 5'd20;
            #1;
            checks++; if ({wb0_ready, wb1_ready} !== exp_ready) begin failures++;
                $display("FAIL rr_ready[%0d] got=%b exp=%b", i, {wb0_ready, wb1_ready},
                         exp_ready); end
            @(posedge clk); #1;
            checks++; if ({gpr_wr_en, gpr_index_rd} !== {1'b1, exp_idx}) begin failures++;
                $display("FAIL rr_index[%0d] got=%0b/%0d exp=1/%0d", i, gpr_wr_en,
                         gpr_index_rd, exp_idx); end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        sb_set = 1'b1; sb_rd = 5'd7; chk_rs2 = 5'd7;
        #1;
        checks++; if (stall !== 1'b0) begin failures++;
            $display("FAIL sb_stall_before_edge got=%0b exp=0", stall); end
        @(negedge clk);
        sb_set = 1'b0;
        #1;
        checks++; if (stall !== 1'b1) begin failures++;
            $display("FAIL sb_stall_set got=%0b exp=1", stall); end
        wb1_valid = 1'b1; wb1_rd = 5'd7; wb1_data = 64'h77;
        #1;
        checks++; if ({wb1_ready, stall} !== 2'b11) begin failures++;
            $display("FAIL sb_accept got=%b exp=11", {wb1_ready, stall}); end
        @(posedge clk); #1;
        checks++; if ({stall, gpr_wr_en, gpr_index_rd, gpr_data_rd} !==
                      {1'b0, 1'b1, 5'd7, 64'h77}) begin failures++;
            $display("FAIL sb_clear got=%0b/%0b/%0d/%0h exp=0/1/7/77", stall, gpr_wr_en,
                     gpr_index_rd, gpr_data_rd); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_set_clear_same();
        @(negedge clk);
        sb_set = 1'b1; sb_rd = 5'd9; chk_rd = 5'd9;
        @(negedge clk);
        wb1_valid = 1'b1; wb1_rd = 5'd9; wb1_data = 64'h99;
        @(posedge clk); #1;
        checks++; if (stall !== 1'b1) begin failures++;
            $display("FAIL set_wins got=%0b exp=1", stall); end
        @(negedge clk);
        sb_set = 1'b0;
        @(posedge clk); #1;
        checks++; if (stall !== 1'b0) begin failures++;
            $display("FAIL set_then_clear got=%0b exp=0", stall); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_rd_zero();
        @(negedge clk);
        sb_set = 1'b1; sb_rd = 5'd4;
        @(negedge clk);
        sb_set = 1'b0; chk_rs1 = 5'd4;
        wb1_valid = 1'b1; wb1_rd = 5'd0; wb1_data = 64'hFF;
        #1;
        checks++; if (wb1_ready !== 1'b1) begin failures++;
            $display("FAIL rd0_ready got=%0b exp=1", wb1_ready); end
        @(posedge clk); #1;
        checks++; if ({gpr_wr_en, stall} !== 2'b01) begin failures++;
            $display("FAIL rd0_no_write got=%b exp=01", {gpr_wr_en, stall}); end
        @(negedge clk);
        idle_inputs();
        sb_set = 1'b1; sb_rd = 5'd0;
        @(negedge clk);
        sb_set = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin failures++;
            $display("FAIL sb_x0 got=%0b exp=0", stall); end
        pulse_reset();
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        sb_set = 1'b1; sb_rd = 5'd3;
        @(negedge clk);
        sb_set = 1'b0;
        wb0_valid = 1'b1; wb0_rd = 5'd6; wb0_data = 64'h66;
        @(posedge clk); #1;
        wb0_valid = 1'b0;
        chk_rs1 = 5'd6; chk_rs2 = 5'd3;
        #1;
        checks++; if ({gpr_wr_en, stall} !== 2'b11) begin failures++;
            $display("FAIL pre_rst got=%b exp=11", {gpr_wr_en, stall}); end
`ifdef GPR_WB_FWD_EN
        checks++; if ({fwd_rs1_hit, fwd_rs2_hit, fwd_data} !== {2'b10, 64'h66}) begin
            failures++;
            $display("FAIL fwd_hit got=%0b%0b/%0h exp=10/66", fwd_rs1_hit, fwd_rs2_hit,
                     fwd_data); end
`else
        checks++; if ({fwd_rs1_hit, fwd_rs2_hit, fwd_data} !== '0) begin failures++;
            $display("FAIL fwd_tied got=%0b%0b/%0h exp=0", fwd_rs1_hit, fwd_rs2_hit,
                     fwd_data); end
`endif
        chk_rs1 = 5'd0;
        #1;
        checks++; if (fwd_rs1_hit !== 1'b0) begin failures++;
            $display("FAIL fwd_x0 got=%0b exp=0", fwd_rs1_hit); end
        rstn = 1'b0;
        #1;
        checks++; if ({gpr_wr_en, gpr_index_rd, gpr_data_rd, stall} !== '0) begin failures++;
            $display("FAIL async_rst got=%0b/%0d/%0h/%0b exp=0/0/0/0", gpr_wr_en,
                     gpr_index_rd, gpr_data_rd, stall); end
        @(negedge clk);
        rstn = 1'b1;
        wb0_valid = 1'b1; wb0_rd = 5'd1; wb0_data = 64'h1;
        wb1_valid = 1'b1; wb1_rd = 5'd2; wb1_data = 64'h2;
        #1;
        checks++; if ({wb0_ready, wb1_ready, stall} !== 3'b100) begin failures++;
            $display("FAIL post_rst_tie got=%b exp=100", {wb0_ready, wb1_ready, stall}); end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_wb0_only();
        test_back_to_back();
        test_scoreboard();
        test_set_clear_same();
        test_rd_zero();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
